// File: rtl/mem_responder.sv
`default_nettype none
//==============================================================================
// Module     : mem_responder
// Description: Word-addressed RAM behind a four-phase req/ack handshake, with
//              configurable wait states and out-of-range flagging.
// Revision   : 1.0 - initial release
//==============================================================================
module mem_responder #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 16,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ack,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic              busy
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WAIT    = 2'd1;
    localparam logic [1:0] S_ACK     = 2'd2;
    localparam logic [1:0] S_RELEASE = 2'd3;
    localparam int         IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] C_WAIT    = 4'(WAIT_CYCLES);

    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              ack_q, ack_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              w_in_range;
    logic              w_enter_ack;
    logic              w_mem_we;
    logic [IDX_W-1:0]  w_idx;

    assign w_in_range  = (32'(addr_q) < 32'(DEPTH));
    assign w_idx       = addr_q[IDX_W-1:0];
    assign w_enter_ack = (state_q == S_WAIT) && (cnt_q == 4'd0);

    // State register; the RAM array deliberately sits outside the reset domain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            ack_q   <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            mem_q[w_idx] <= wdata_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    state_d = S_WAIT;
                    cnt_d   = C_WAIT;
                    addr_d  = addr;
                    we_d    = we;
                    wdata_d = wdata;
                end
            end
            S_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                if (!req) begin
                    state_d = S_RELEASE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Data-side effects happen only on the WAIT->ACK edge.
    always_comb begin
        ack_d    = (state_d == S_ACK);
        busy_d   = (state_d != S_IDLE);
        rdata_d  = rdata_q;
        err_d    = err_q;
        w_mem_we = 1'b0;
        if (w_enter_ack) begin
            err_d    = !w_in_range;
            w_mem_we = we_q && w_in_range;
            if (!we_q) begin
                rdata_d = w_in_range ? mem_q[w_idx] : '0;
            end
        end
    end

    assign ack   = ack_q;
    assign rdata = rdata_q;
    assign err   = err_q;
    assign busy  = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
//==============================================================================
// Module     : tb_mem_responder
// Description: Directed bench for mem_responder with an expected-result queue.
// Revision   : 1.0 - initial release
//==============================================================================
module tb_mem_responder;

    typedef struct {
        logic [15:0] data;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [7:0]  addr0 = '0, addr1 = '0;
    logic [15:0] wdata0 = '0, wdata1 = '0;
    logic        ack0, err0, busy0, ack1, err1, busy1;
    logic [15:0] rdata0, rdata1;

    int          n_cmp = 0;
    int          n_mis = 0;
    int          cyc = 0;
    exp_t        sb[$];
    logic [15:0] model [2][256];
    logic [15:0] last_rd [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance 0: DEPTH=128, two wait states. Instance 1: full depth, no wait states.
    mem_responder #(.ADDR_W(8), .DATA_W(16), .DEPTH(128), .WAIT_CYCLES(2)) u_dut0 (
        .clk(clk), .rst(rst), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
        .ack(ack0), .rdata(rdata0), .err(err0), .busy(busy0)
    );
    mem_responder #(.ADDR_W(8), .DATA_W(16), .DEPTH(256), .WAIT_CYCLES(0)) u_dut1 (
        .clk(clk), .rst(rst), .req(req1), .we(we1), .addr(addr1), .wdata(wdata1),
        .ack(ack1), .rdata(rdata1), .err(err1), .busy(busy1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic get_ack(input int sel);
        return (sel == 0) ? ack0 : ack1;
    endfunction
    function automatic logic get_busy(input int sel);
        return (sel == 0) ? busy0 : busy1;
    endfunction

    task automatic set_req(input int sel, input logic r);
        if (sel == 0) req0 = r; else req1 = r;
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic xact(input int sel, input bit w, input logic [7:0] a,
                        input logic [15:0] d, input bit short_req);
        int   depth;
        int   lat;
        int   k;
        bit   got;
        exp_t e;
        depth = (sel == 0) ? 128 : 256;
        lat   = (sel == 0) ? 4 : 2;
        if (sel == 0) begin we0 = w; addr0 = a; wdata0 = d; end
        else          begin we1 = w; addr1 = a; wdata1 = d; end
        set_req(sel, 1'b1);
        e.err = (int'(a) >= depth);
        if (w) begin
            e.data = last_rd[sel];
            if (!e.err) model[sel][a] = d;
        end else begin
            e.data = e.err ? 16'h0000 : model[sel][a];
            last_rd[sel] = e.data;
        end
        sb.push_back(e);
        k   = 0;
        got = 0;
        while (!got && k < 40) begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                chk("busy_after_accept", 32'(get_busy(sel)), 32'd1);
                if (short_req) set_req(sel, 1'b0);
            end
            if (get_ack(sel)) got = 1;
        end
        chk("ack_latency", 32'(k), 32'(lat));
        if (got) begin
            e = sb.pop_front();
            chk("rdata", 32'((sel == 0) ? rdata0 : rdata1), 32'(e.data));
            chk("err", 32'((sel == 0) ? err0 : err1), 32'(e.err));
        end
        set_req(sel, 1'b0);
        @(negedge clk);
        chk("ack_drop", 32'(get_ack(sel)), 32'd0);
        chk("busy_release", 32'(get_busy(sel)), 32'd1);
        @(negedge clk);
        chk("busy_idle", 32'(get_busy(sel)), 32'd0);
    endtask

    initial begin
        int t0;
        int t1;
        last_rd[0] = 16'h0000;
        last_rd[1] = 16'h0000;

        // Reset and idle
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 1) rst = 1'b1;
            chk("rst_ack", 32'({ack0, ack1}), 32'd0);
            chk("rst_rdata", 32'({rdata0, rdata1}), 32'd0);
            chk("rst_err_busy", 32'({err0, err1, busy0, busy1}), 32'd0);
        end

        // Write then read
        xact(0, 1'b1, 8'h10, 16'hBEEF, 1'b0);
        xact(0, 1'b0, 8'h10, 16'h0000, 1'b0);

        // Out-of-range and boundary addresses on the 128-word instance
        xact(0, 1'b1, 8'h10, 16'hA5A5, 1'b0);
        xact(0, 1'b1, 8'h90, 16'h1234, 1'b0);
        xact(0, 1'b0, 8'h90, 16'h0000, 1'b0);
        xact(0, 1'b0, 8'h10, 16'h0000, 1'b0);
        xact(0, 1'b1, 8'h7F, 16'hC3C3, 1'b0);
        xact(0, 1'b1, 8'h80, 16'h9999, 1'b0);
        xact(0, 1'b0, 8'h7F, 16'h0000, 1'b0);
        xact(0, 1'b0, 8'h80, 16'h0000, 1'b0);
        xact(0, 1'b0, 8'h00, 16'h0000, 1'b1);

        // Abort by reset during WAIT
        xact(0, 1'b1, 8'h20, 16'h0001, 1'b0);
        req0 = 1'b1; we0 = 1'b1; addr0 = 8'h20; wdata0 = 16'h5555;
        @(negedge clk);
        chk("abort_busy_wait", 32'(busy0), 32'd1);
        rst  = 1'b0;
        req0 = 1'b0;
        #1;
        chk("abort_async_busy", 32'(busy0), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_no_ack", 32'(ack0), 32'd0);
        end
        rst = 1'b1;
        @(negedge clk);
        chk("abort_rdata_reset", 32'(rdata0), 32'd0);
        chk("abort_err_reset", 32'(err0), 32'd0);
        last_rd[0] = 16'h0000;
        last_rd[1] = 16'h0000;
        xact(0, 1'b0, 8'h20, 16'h0000, 1'b0);

        // Short req: ack pulses for one cycle and the read still completes
        xact(0, 1'b1, 8'h05, 16'h0077, 1'b0);
        xact(0, 1'b0, 8'h05, 16'h0000, 1'b1);

        // No wait states, back-to-back reads
        xact(1, 1'b1, 8'h01, 16'h0011, 1'b0);
        xact(1, 1'b1, 8'h02, 16'h0022, 1'b0);
        xact(1, 1'b1, 8'hFF, 16'hF00D, 1'b0);
        t0 = cyc;
        xact(1, 1'b0, 8'h01, 16'h0000, 1'b0);
        t1 = cyc;
        xact(1, 1'b0, 8'h02, 16'h0000, 1'b0);
        chk("accept_spacing", 32'(t1 - t0), 32'd4);
        xact(1, 1'b0, 8'hFF, 16'h0000, 1'b0);

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
